// File: rtl/uart_stream_bridge.sv
// Buffered RX-to-TX stream bridge: FIFO with enqueue transform, hold mode, backpressure or drop-on-full.
// Optional traffic statistics are compiled in with the UART_BRIDGE_STATS_EN macro.
module uart_stream_bridge #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    input  logic                       stat_clr,
    output logic [15:0]                stat_words,
    output logic [15:0]                stat_drops
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic [DATA_W-1:0] xform(input logic [1:0] m, input logic [DATA_W-1:0] d);
        case (m)
            2'b01:   return ~d;
            2'b10:   return d + DATA_W'(1);
            default: return d;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push, pop, drop;

    assign in_ready  = (DROP_ON_FULL != 0) ? rst_n : (!full_q && !flush && rst_n);
    assign push      = in_valid && in_ready && !flush && !full_q;
    assign out_valid = !empty_q && (mode != 2'b11);
    assign pop       = out_valid && out_ready && !flush;
    // Only the drop-on-full variant discards; flushing cycles never count as drops.
    assign drop      = (DROP_ON_FULL != 0) && in_valid && full_q && !flush && rst_n;

    assign out_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; out_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= xform(mode, in_data);
    end

`ifdef UART_BRIDGE_STATS_EN
    logic [15:0] stat_words_q, stat_words_d;
    logic [15:0] stat_drops_q, stat_drops_d;

    always_comb begin
        stat_words_d = stat_words_q;
        stat_drops_d = stat_drops_q;
        if (stat_clr) begin
            stat_words_d = '0;
            stat_drops_d = '0;
        end else begin
            if (pop)  stat_words_d = sat_inc(stat_words_q);
            if (drop) stat_drops_d = sat_inc(stat_drops_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_words_q <= '0;
            stat_drops_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_drops_q <= stat_drops_d;
        end
    end

    assign stat_words = stat_words_q;
    assign stat_drops = stat_drops_q;
`else
    logic unused_stat;
    assign unused_stat = stat_clr ^ drop ^ (sat_inc(16'd0) == 16'd0);
    assign stat_words  = '0;
    assign stat_drops  = '0;
`endif

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge: backpressure instance (a) and drop-on-full instance (b).
module tb_uart_stream_bridge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  mode_a, mode_b;
    logic        flush_a, flush_b, in_valid_a, in_valid_b, out_ready_a, out_ready_b;
    logic        stat_clr_a, stat_clr_b;
    logic [7:0]  in_data_a, in_data_b, out_data_a, out_data_b;
    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [4:0]  count_a, count_b;
    logic        full_a, full_b, empty_a, empty_b;
    logic [15:0] stat_words_a, stat_words_b, stat_drops_a, stat_drops_b;

    uart_stream_bridge #(.DATA_W(8), .DEPTH(16), .DROP_ON_FULL(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .flush(flush_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
        .count(count_a), .full(full_a), .empty(empty_a),
        .stat_clr(stat_clr_a), .stat_words(stat_words_a), .stat_drops(stat_drops_a)
    );

    uart_stream_bridge #(.DATA_W(8), .DEPTH(16), .DROP_ON_FULL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .flush(flush_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .count(count_b), .full(full_b), .empty(empty_b),
        .stat_clr(stat_clr_b), .stat_words(stat_words_b), .stat_drops(stat_drops_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int v);
`ifdef UART_BRIDGE_STATS_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mode_a = 2'b00; flush_a = 0; in_valid_a = 0; in_data_a = 8'h00; out_ready_a = 0; stat_clr_a = 0;
        mode_b = 2'b00; flush_b = 0; in_valid_b = 0; in_data_b = 8'h00; out_ready_b = 0; stat_clr_b = 0;
        step();
        step();
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_stat_words", 32'(stat_words_a), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready_a), 32'd1);

        // pass-through order with a ready sink
        out_ready_a = 1; in_valid_a = 1; in_data_a = 8'h41;
        step();
        chk("pass_41", 32'(out_data_a), 32'h41);
        chk("pass_fwft", 32'(out_valid_a), 32'd1);
        in_data_a = 8'h42;
        step();
        chk("pass_42", 32'(out_data_a), 32'h42);
        chk("pass_cnt1", 32'(count_a), 32'd1);
        in_data_a = 8'h43;
        step();
        chk("pass_43", 32'(out_data_a), 32'h43);
        in_valid_a = 0;
        step();
        chk("pass_cnt0", 32'(count_a), 32'd0);
        chk("pass_empty", 32'(empty_a), 32'd1);
        chk("pass_stat_words", 32'(stat_words_a), sx(3));

        // transforms and stall stability across mode changes
        out_ready_a = 0; mode_a = 2'b01; in_valid_a = 1; in_data_a = 8'h0F;
        step();
        in_valid_a = 0;
        chk("inv_0f", 32'(out_data_a), 32'hF0);
        mode_a = 2'b10;
        step();
        chk("stall_m2", 32'(out_data_a), 32'hF0);
        mode_a = 2'b11;
        #1;
        chk("stall_m3_valid", 32'(out_valid_a), 32'd0);
        chk("stall_m3_data", 32'(out_data_a), 32'hF0);
        mode_a = 2'b00; out_ready_a = 1;
        step();
        out_ready_a = 0;
        chk("inv_drained", 32'(empty_a), 32'd1);
        mode_a = 2'b10; in_valid_a = 1; in_data_a = 8'hFF;
        step();
        in_valid_a = 0;
        chk("inc_ff", 32'(out_data_a), 32'h00);
        chk("inc_valid", 32'(out_valid_a), 32'd1);
        out_ready_a = 1;
        step();
        out_ready_a = 0; mode_a = 2'b00;
        chk("inc_cnt0", 32'(count_a), 32'd0);
        chk("inc_stat_words", 32'(stat_words_a), sx(5));

        // backpressure: 17 offered, 16 stored, 17th held upstream
        for (int i = 0; i < 16; i++) begin
            in_valid_a = 1; in_data_a = 8'(8'h10 + i);
            step();
        end
        in_data_a = 8'h20;
        #1;
        chk("bp_count16", 32'(count_a), 32'd16);
        chk("bp_full", 32'(full_a), 32'd1);
        chk("bp_in_ready0", 32'(in_ready_a), 32'd0);
        step();
        chk("bp_held", 32'(count_a), 32'd16);
        out_ready_a = 1;
        step();
        out_ready_a = 0;
        chk("bp_no_wt_count", 32'(count_a), 32'd15);
        chk("bp_in_ready1", 32'(in_ready_a), 32'd1);
        step();
        in_valid_a = 0;
        chk("bp_refill", 32'(count_a), 32'd16);
        out_ready_a = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("bp_drain%0d", i), 32'(out_data_a), 32'(8'h11 + i));
            step();
        end
        out_ready_a = 0;
        chk("bp_empty", 32'(empty_a), 32'd1);
        chk("bp_stat_words", 32'(stat_words_a), sx(22));

        // hold mode pauses draining but still stores
        mode_a = 2'b11; out_ready_a = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1; in_data_a = 8'(8'hA0 + i);
            step();
        end
        in_valid_a = 0;
        chk("hold_valid", 32'(out_valid_a), 32'd0);
        chk("hold_count", 32'(count_a), 32'd4);
        mode_a = 2'b00;
        #1;
        chk("hold_release", 32'(out_valid_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_drain%0d", i), 32'(out_data_a), 32'(8'hA0 + i));
            step();
        end
        out_ready_a = 0;
        chk("hold_cnt0", 32'(count_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid_a = 1; in_data_a = 8'(8'hB0 + i);
            step();
        end
        chk("fl_count5", 32'(count_a), 32'd5);
        in_data_a = 8'hC0; flush_a = 1;
        #1;
        chk("fl_in_ready", 32'(in_ready_a), 32'd0);
        step();
        flush_a = 0; in_valid_a = 0;
        chk("fl_count", 32'(count_a), 32'd0);
        chk("fl_empty", 32'(empty_a), 32'd1);
        chk("fl_drops_a", 32'(stat_drops_a), 32'd0);

        // drop-on-full instance
        for (int i = 0; i < 16; i++) begin
            in_valid_b = 1; in_data_b = 8'(8'h50 + i);
            step();
        end
        chk("drop_full", 32'(full_b), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_data_b = 8'(8'h70 + i);
            #1;
            chk($sformatf("drop_in_ready%0d", i), 32'(in_ready_b), 32'd1);
            step();
        end
        in_valid_b = 0;
        chk("drop_count", 32'(count_b), 32'd16);
        chk("drop_stat", 32'(stat_drops_b), sx(3));
        out_ready_b = 1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drop_drain%0d", i), 32'(out_data_b), 32'(8'h50 + i));
            step();
        end
        out_ready_b = 0;
        chk("drop_empty", 32'(empty_b), 32'd1);
        chk("drop_words", 32'(stat_words_b), sx(16));
        for (int i = 0; i < 16; i++) begin
            in_valid_b = 1; in_data_b = 8'(8'h60 + i);
            step();
        end
        in_data_b = 8'h7F; flush_b = 1;
        step();
        flush_b = 0; in_valid_b = 0;
        chk("drop_flush_count", 32'(count_b), 32'd0);
        chk("drop_flush_nodrop", 32'(stat_drops_b), sx(3));
        stat_clr_b = 1;
        step();
        stat_clr_b = 0;
        chk("clr_drops", 32'(stat_drops_b), 32'd0);
        chk("clr_words", 32'(stat_words_b), 32'd0);

        // reset mid-operation
        for (int i = 0; i < 7; i++) begin
            in_valid_a = 1; in_data_a = 8'(8'hD0 + i);
            step();
        end
        in_valid_a = 0;
        chk("mid_count7", 32'(count_a), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", 32'(in_ready_a), 32'd0);
        step();
        rst_n = 1'b1;
        chk("mid_count", 32'(count_a), 32'd0);
        chk("mid_out_valid", 32'(out_valid_a), 32'd0);
        chk("mid_out_data", 32'(out_data_a), 32'd0);
        chk("mid_empty", 32'(empty_a), 32'd1);
        chk("mid_words", 32'(stat_words_a), 32'd0);
        chk("mid_drops", 32'(stat_drops_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
